// File: rtl/servo_array_ctrl_if.sv
// Byte link between the servo controller and the UART rx/tx pair.
// The receiver side supplies rx bytes and tx_busy; the controller answers with tx_data/tx_send.
interface servo_array_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_new;
  logic [7:0] tx_data;
  logic       tx_send;
  logic       tx_busy;

  modport master (output rx_data, rx_new, tx_busy, input tx_data, tx_send);
  modport slave  (input rx_data, rx_new, tx_busy, output tx_data, tx_send);
endinterface

// File: rtl/servo_array_ctrl.sv
// N-channel servo controller: 0xFF/CH/POS frame parser, slew-limited positions, per-channel PWM.
// Targets update on the POS byte; the one-entry ACK/NAK slot waits for tx_busy low (latest response wins).
module servo_array_ctrl #(
  parameter int NUM_CH     = 4,
  parameter int PWM_PERIOD = 1000000,
  parameter int PULSE_MIN  = 50000,
  parameter int PULSE_STEP = 196,
  parameter int SLEW_DIV   = 250000,
  parameter int SLEW_STEP  = 1,
  parameter int RESET_POS  = 128,
  parameter int TIMEOUT    = 500000
) (
  input  logic                clk,
  input  logic                rst,
  servo_array_ctrl_if.slave   io_ser,
  output logic [8*NUM_CH-1:0] o_pos_out,
  output logic [NUM_CH-1:0]   o_pwm_out,
  output logic                o_frame_err
);
  localparam int PW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam int SW = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] PWM_LAST  = PW'(PWM_PERIOD - 1);
  localparam logic [SW-1:0] SLEW_LAST = SW'(SLEW_DIV - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [8:0]    STEP9     = 9'(SLEW_STEP);
  localparam logic [7:0]    RST_POS   = 8'(RESET_POS);
  localparam logic [7:0]    BYTE_HDR   = 8'hFF;
  localparam logic [7:0]    BYTE_BCAST = 8'hFE;
  localparam logic [7:0]    BYTE_ACK   = 8'h06;
  localparam logic [7:0]    BYTE_NAK   = 8'h15;

  typedef enum logic [1:0] {ST_IDLE, ST_GOT_HDR, ST_GOT_CH} state_t;

  state_t            r_state;
  logic [7:0]        r_ch;
  logic [TW-1:0]     r_to_cnt;
  logic              r_frame_err;
  logic              r_pend;
  logic [7:0]        r_pend_dat;
  logic [7:0]        r_tx_data;
  logic              r_tx_send;
  logic [7:0]        r_target [NUM_CH];
  logic [7:0]        r_cur [NUM_CH];
  logic [SW-1:0]     r_tick_cnt;
  logic [PW-1:0]     r_pwm_cnt;
  logic [31:0]       r_width [NUM_CH];
  logic [NUM_CH-1:0] r_pwm;

  logic              w_ch_ok;
  logic              w_ack;
  logic              w_nak;
  logic              w_timeout;
  logic              w_send;
  logic              w_tick;
  logic [31:0]       w_width_new [NUM_CH];

  always_comb begin
    w_ch_ok   = (io_ser.rx_data < 8'(NUM_CH)) || (io_ser.rx_data == BYTE_BCAST);
    w_ack     = io_ser.rx_new && (r_state == ST_GOT_CH);
    w_nak     = io_ser.rx_new && (r_state == ST_GOT_HDR) && !w_ch_ok && (io_ser.rx_data != BYTE_HDR);
    w_timeout = !io_ser.rx_new && (r_state != ST_IDLE) && (r_to_cnt == TO_LAST);
    w_send    = r_pend && !io_ser.tx_busy && !r_tx_send;
    w_tick    = (r_tick_cnt == SLEW_LAST);
    for (int i = 0; i < NUM_CH; i++) begin
      w_width_new[i] = 32'(PULSE_MIN) + 32'(r_cur[i]) * 32'(PULSE_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ch        <= '0;
      r_to_cnt    <= '0;
      r_frame_err <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) r_target[i] <= RST_POS;
    end else begin
      r_frame_err <= w_nak || w_timeout;
      if (io_ser.rx_new || (r_state == ST_IDLE)) r_to_cnt <= '0;
      else                                       r_to_cnt <= r_to_cnt + TW'(1);

      if (w_timeout) begin
        r_state <= ST_IDLE;
      end else if (io_ser.rx_new) begin
        case (r_state)
          ST_IDLE: begin
            if (io_ser.rx_data == BYTE_HDR) r_state <= ST_GOT_HDR;
          end
          ST_GOT_HDR: begin
            // A repeated 0xFF is treated as a fresh header so the stream can resync.
            if (w_ch_ok) begin
              r_state <= ST_GOT_CH;
              r_ch    <= io_ser.rx_data;
            end else if (io_ser.rx_data != BYTE_HDR) begin
              r_state <= ST_IDLE;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            for (int i = 0; i < NUM_CH; i++) begin
              if ((r_ch == BYTE_BCAST) || (r_ch == 8'(i))) r_target[i] <= io_ser.rx_data;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend     <= 1'b0;
      r_pend_dat <= '0;
      r_tx_data  <= '0;
      r_tx_send  <= 1'b0;
    end else begin
      r_tx_send <= w_send;
      if (w_send) r_tx_data <= r_pend_dat;
      if (w_ack || w_nak) begin
        r_pend     <= 1'b1;
        r_pend_dat <= w_ack ? BYTE_ACK : BYTE_NAK;
      end else if (w_send) begin
        r_pend <= 1'b0;
      end
    end
  end

  // Borrow out of the 9-bit subtract means the step would pass below zero.
  function automatic logic [7:0] slew(input logic [7:0] cur, input logic [7:0] tgt);
    logic [8:0] up;
    logic [8:0] dn;
    up = {1'b0, cur} + STEP9;
    dn = {1'b0, cur} - STEP9;
    if (cur < tgt)      return (up > {1'b0, tgt}) ? tgt : up[7:0];
    else if (cur > tgt) return (dn[8] || (dn[7:0] < tgt)) ? tgt : dn[7:0];
    else                return cur;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_cnt <= '0;
      for (int i = 0; i < NUM_CH; i++) r_cur[i] <= RST_POS;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + SW'(1);
      for (int i = 0; i < NUM_CH; i++) begin
        if (SLEW_STEP == 0) r_cur[i] <= r_target[i];
        else if (w_tick)    r_cur[i] <= slew(r_cur[i], r_target[i]);
      end
    end
  end

  // At counter zero the freshly latched width is used, so the very first period is full length.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwm_cnt <= '0;
      r_pwm     <= '0;
      for (int i = 0; i < NUM_CH; i++) r_width[i] <= '0;
    end else begin
      r_pwm_cnt <= (r_pwm_cnt == PWM_LAST) ? '0 : r_pwm_cnt + PW'(1);
      for (int i = 0; i < NUM_CH; i++) begin
        if (r_pwm_cnt == '0) begin
          r_width[i] <= w_width_new[i];
          r_pwm[i]   <= 32'(r_pwm_cnt) < w_width_new[i];
        end else begin
          r_pwm[i]   <= 32'(r_pwm_cnt) < r_width[i];
        end
      end
    end
  end

  assign io_ser.tx_data = r_tx_data;
  assign io_ser.tx_send = r_tx_send;
  assign o_frame_err    = r_frame_err;
  assign o_pwm_out      = r_pwm;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pos
    assign o_pos_out[8*g +: 8] = r_cur[g];
  end
endmodule
